// File: rtl/ram_pkg.sv
// Shared definitions for the burst master and its read-side skid buffer.
// RAM rw encoding and the burst FSM state type.
package ram_pkg;

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } burst_state_t;

endpackage

// File: rtl/ram_read_skid_buffer.sv
// Two-entry FIFO of {data, last} that absorbs read data returned by the RAM
// while the consumer is stalled. Simultaneous push and pop are allowed.
module ram_read_skid_buffer #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  push_last_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic                  head_last_o,
   output logic [1:0]            count_o
);

   logic                      wr_ptr_q;
   logic                      rd_ptr_q;
   logic [1:0]                count_q;
   logic [1:0][DATA_WIDTH-1:0] entry_data;
   logic [1:0]                entry_last;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] data_q;
         logic                  last_q;

         always_ff @(posedge clock) begin
            if (!reset_n) begin
               data_q <= '0;
               last_q <= 1'b0;
            end else if (push_i && (wr_ptr_q == 1'(gi))) begin
               data_q <= push_data_i;
               last_q <= push_last_i;
            end
         end

         assign entry_data[gi] = data_q;
         assign entry_last[gi] = last_q;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_data_o = entry_data[rd_ptr_q];
   assign head_last_o = entry_last[rd_ptr_q];
   assign count_o     = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: accepts one read or write
// burst, walks sequential addresses and returns read beats through a skid buffer.
module ram_burst_master
   import ram_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int LEN_WIDTH     = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_rw,
   input  logic [ADDRESS_WIDTH-1:0] req_address,
   input  logic [LEN_WIDTH-1:0]     req_length,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_last,
   output logic                     busy,
   output logic                     done,
   output logic                     ram_enable,
   output logic                     ram_rw,
   output logic [ADDRESS_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0]    ram_data_in,
   input  logic [DATA_WIDTH-1:0]    ram_data_out
);

   burst_state_t             state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]     remain_q, remain_d;
   logic                     inflight_q, inflight_d;
   logic                     inflight_last_q, inflight_last_d;
   logic                     done_q, done_d;
   logic [DATA_WIDTH-1:0]    wdata_hold_q, wdata_hold_d;

   logic                     wr_beat;
   logic                     rd_issue;
   logic                     rd_pop;
   logic                     last_beat;
   logic [2:0]               occupancy;
   logic [1:0]               skid_count;
   logic                     skid_last;
   logic [DATA_WIDTH-1:0]    skid_data;

   assign last_beat = (remain_q == LEN_WIDTH'(1));
   assign wr_beat   = (state_q == WRITE) && wr_valid;
   // Buffered plus in-flight beats may never exceed the two skid slots.
   assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q};
   assign rd_issue  = (state_q == READ) && (occupancy < 3'd2);
   assign rd_valid  = (skid_count != 2'd0);
   assign rd_pop    = rd_valid && rd_ready;

   ram_read_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (inflight_q),
      .push_data_i (ram_data_out),
      .push_last_i (inflight_last_q),
      .pop_i       (rd_pop),
      .head_data_o (skid_data),
      .head_last_o (skid_last),
      .count_o     (skid_count)
   );

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      remain_d        = remain_q;
      done_d          = 1'b0;
      wdata_hold_d    = wdata_hold_q;
      inflight_d      = rd_issue;
      inflight_last_d = rd_issue && last_beat;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_length == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = (req_rw == RAM_WRITE) ? WRITE : READ;
                  addr_d   = req_address;
                  remain_d = req_length;
               end
            end
         end
         WRITE: begin
            if (wr_beat) begin
               addr_d       = addr_q + ADDRESS_WIDTH'(1);
               remain_d     = remain_q - LEN_WIDTH'(1);
               wdata_hold_d = wr_data;
               if (last_beat) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (rd_issue) begin
               addr_d   = addr_q + ADDRESS_WIDTH'(1);
               remain_d = remain_q - LEN_WIDTH'(1);
               if (last_beat) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (rd_pop && skid_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
         wdata_hold_q    <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remain_q        <= remain_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
         wdata_hold_q    <= wdata_hold_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign wr_ready    = (state_q == WRITE);
   assign busy        = (state_q != IDLE);
   // Read completion is reported in the acceptance cycle; others a cycle later.
   assign done        = done_q || ((state_q == DRAIN) && rd_pop && skid_last);
   assign ram_enable  = wr_beat || rd_issue;
   assign ram_rw      = wr_beat ? RAM_WRITE : RAM_READ;
   assign ram_address = addr_q;
   assign ram_data_in = wr_beat ? wr_data : wdata_hold_q;
   assign rd_data     = skid_data;
   assign rd_last     = skid_last;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM
// (read data one cycle after the command) and a bus monitor.
module tb_ram_burst_master;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_rw;
   logic [15:0] req_address;
   logic [7:0]  req_length;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_data;
   logic        rd_valid, rd_ready, rd_last;
   logic [15:0] rd_data;
   logic        busy, done;
   logic        ram_enable, ram_rw;
   logic [15:0] ram_address, ram_data_in, ram_data_out;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   ram_burst_master #(
      .ADDRESS_WIDTH (16),
      .DATA_WIDTH    (16),
      .LEN_WIDTH     (8)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rw       (req_rw),
      .req_address  (req_address),
      .req_length   (req_length),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .rd_last      (rd_last),
      .busy         (busy),
      .done         (done),
      .ram_enable   (ram_enable),
      .ram_rw       (ram_rw),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out)
   );

   logic [15:0] mem [0:65535];
   always @(posedge clock) begin
      if (ram_enable) begin
         if (ram_rw) mem[ram_address] <= ram_data_in;
         else        ram_data_out     <= mem[ram_address];
      end
   end

   // Bus monitor: RAM command log and outstanding-read high-water mark.
   logic [15:0] log_addr [$];
   logic [15:0] log_data [$];
   logic        log_rw   [$];
   int issued = 0, accepted = 0, max_out = 0;
   always @(posedge clock) begin
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (ram_enable) begin
         log_addr.push_back(ram_address);
         log_data.push_back(ram_data_in);
         log_rw.push_back(ram_rw);
         if (!ram_rw) issued++;
      end
      if (rd_valid && rd_ready) accepted++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_rw.delete();
      issued   = 0;
      accepted = 0;
      max_out  = 0;
   endtask

   logic [15:0] t2_data [4];
   logic [15:0] beat_data [4];
   logic        beat_last [4];
   logic        beat_done [4];
   int          got;
   int          seen;
   logic        v;

   initial begin
      reset_n     = 1'b0;
      req_valid   = 1'b0;
      req_rw      = 1'b0;
      req_address = '0;
      req_length  = '0;
      wr_valid    = 1'b0;
      wr_data     = '0;
      rd_ready    = 1'b1;
      t2_data[0] = 16'h1111; t2_data[1] = 16'h2222;
      t2_data[2] = 16'h3333; t2_data[3] = 16'h4444;
      tick();
      tick();

      // Reset state
      check("rst_req_ready",   32'(req_ready),   32'd1);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_done",        32'(done),        32'd0);
      check("rst_wr_ready",    32'(wr_ready),    32'd0);
      check("rst_rd_valid",    32'(rd_valid),    32'd0);
      check("rst_ram_enable",  32'(ram_enable),  32'd0);
      check("rst_ram_rw",      32'(ram_rw),      32'd0);
      check("rst_ram_address", 32'(ram_address), 32'd0);
      check("rst_ram_data_in", 32'(ram_data_in), 32'd0);
      reset_n = 1'b1;
      tick();

      // Test 1: single-beat write then single-beat read
      clear_log();
      req_valid = 1'b1; req_rw = 1'b1; req_address = 16'h0010; req_length = 8'd1;
      #1;
      check("t1w_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      wr_valid = 1'b1; wr_data = 16'hBEEF;
      #1;
      check("t1w_wr_ready", 32'(wr_ready),    32'd1);
      check("t1w_enable",   32'(ram_enable),  32'd1);
      check("t1w_rw",       32'(ram_rw),      32'd1);
      check("t1w_addr",     32'(ram_address), 32'h0010);
      check("t1w_data",     32'(ram_data_in), 32'hBEEF);
      tick();
      wr_valid = 1'b0;
      #1;
      check("t1w_done",      32'(done),        32'd1);
      check("t1w_busy",      32'(busy),        32'd0);
      check("t1w_hold_data", 32'(ram_data_in), 32'hBEEF);
      check("t1w_log_size",  32'(log_addr.size()), 32'd1);
      tick();
      check("t1w_done_clr",  32'(done), 32'd0);

      clear_log();
      req_valid = 1'b1; req_rw = 1'b0; req_address = 16'h0010; req_length = 8'd1;
      tick();
      req_valid = 1'b0;
      #1;
      check("t1r_enable", 32'(ram_enable),  32'd1);
      check("t1r_rw",     32'(ram_rw),      32'd0);
      check("t1r_addr",   32'(ram_address), 32'h0010);
      tick();
      check("t1r_not_yet_valid", 32'(rd_valid), 32'd0);
      tick();
      check("t1r_valid", 32'(rd_valid), 32'd1);
      check("t1r_data",  32'(rd_data),  32'hBEEF);
      check("t1r_last",  32'(rd_last),  32'd1);
      check("t1r_done",  32'(done),     32'd1);
      tick();
      check("t1r_busy_end",  32'(busy),     32'd0);
      check("t1r_valid_end", 32'(rd_valid), 32'd0);
      check("t1r_done_clr",  32'(done),     32'd0);

      // Test 2: 4-beat write with wr_valid low every other cycle
      clear_log();
      req_valid = 1'b1; req_rw = 1'b1; req_address = 16'h0100; req_length = 8'd4;
      tick();
      req_valid = 1'b0;
      got = 0; v = 1'b0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         wr_valid = v;
         wr_data  = t2_data[got];
         #1;
         if (!v) check("t2_gap_enable", 32'(ram_enable), 32'd0);
         tick();
         if (v) got++;
         v = ~v;
      end
      wr_valid = 1'b0;
      check("t2_beats_taken", 32'(got),  32'd4);
      check("t2_done",        32'(done), 32'd1);
      check("t2_log_size",    32'(log_addr.size()), 32'd4);
      for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
         check($sformatf("t2_addr%0d", k), 32'(log_addr[k]), 32'h0100 + 32'(k));
         check($sformatf("t2_data%0d", k), 32'(log_data[k]), 32'(t2_data[k]));
         check($sformatf("t2_rw%0d", k),   32'(log_rw[k]),   32'd1);
      end
      tick();

      // Test 3: 4-beat read with 3 stall cycles mid-burst
      clear_log();
      req_valid = 1'b1; req_rw = 1'b0; req_address = 16'h0100; req_length = 8'd4;
      tick();
      req_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         rd_ready = !(c >= 3 && c < 6);
         #1;
         if (rd_valid && rd_ready) begin
            beat_data[got] = rd_data;
            beat_last[got] = rd_last;
            beat_done[got] = done;
            got++;
         end
         tick();
      end
      rd_ready = 1'b1;
      check("t3_beats", 32'(got), 32'd4);
      for (int k = 0; k < 4 && k < got; k++) begin
         check($sformatf("t3_data%0d", k), 32'(beat_data[k]), 32'(t2_data[k]));
         check($sformatf("t3_last%0d", k), 32'(beat_last[k]), (k == 3) ? 32'd1 : 32'd0);
         check($sformatf("t3_done%0d", k), 32'(beat_done[k]), (k == 3) ? 32'd1 : 32'd0);
      end
      check("t3_max_out_le2", 32'(max_out <= 2), 32'd1);
      check("t3_issued",      32'(log_addr.size()), 32'd4);
      for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
         check($sformatf("t3_addr%0d", k), 32'(log_addr[k]), 32'h0100 + 32'(k));
      end
      check("t3_busy_end", 32'(busy), 32'd0);

      // Test 4: write burst wrapping past the top of the address space
      clear_log();
      req_valid = 1'b1; req_rw = 1'b1; req_address = 16'hFFFE; req_length = 8'd4;
      tick();
      req_valid = 1'b0;
      wr_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_data = 16'hA000 + 16'(k);
         tick();
      end
      wr_valid = 1'b0;
      check("t4_done",     32'(done), 32'd1);
      check("t4_log_size", 32'(log_addr.size()), 32'd4);
      if (log_addr.size() == 4) begin
         check("t4_addr0", 32'(log_addr[0]), 32'hFFFE);
         check("t4_addr1", 32'(log_addr[1]), 32'hFFFF);
         check("t4_addr2", 32'(log_addr[2]), 32'h0000);
         check("t4_addr3", 32'(log_addr[3]), 32'h0001);
         check("t4_data3", 32'(log_data[3]), 32'hA003);
      end
      tick();

      // Test 5: zero-length request
      clear_log();
      req_valid = 1'b1; req_rw = 1'b0; req_address = 16'h0200; req_length = 8'd0;
      #1;
      check("t5_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      #1;
      check("t5_done",       32'(done),       32'd1);
      check("t5_busy",       32'(busy),       32'd0);
      check("t5_req_ready2", 32'(req_ready),  32'd1);
      check("t5_enable",     32'(ram_enable), 32'd0);
      tick();
      check("t5_done_clr", 32'(done), 32'd0);
      check("t5_no_access", 32'(log_addr.size()), 32'd0);

      // Test 6: reset asserted during beat 2 of a 4-beat read
      req_valid = 1'b1; req_rw = 1'b0; req_address = 16'hFFFE; req_length = 8'd4;
      tick();
      req_valid = 1'b0;
      check("t6_beat1_issue", 32'(ram_enable), 32'd1);
      tick();
      check("t6_beat2_issue", 32'(ram_enable), 32'd1);
      reset_n = 1'b0;
      tick();
      check("t6_rst_enable",    32'(ram_enable), 32'd0);
      check("t6_rst_rd_valid",  32'(rd_valid),   32'd0);
      check("t6_rst_req_ready", 32'(req_ready),  32'd1);
      check("t6_rst_busy",      32'(busy),       32'd0);
      reset_n = 1'b1;
      clear_log();
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (rd_valid) seen++;
      end
      check("t6_no_stale_data", 32'(seen), 32'd0);
      check("t6_no_ram_access", 32'(log_addr.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
